// File: rtl/wave_pkg.sv
// Constants shared by the UART command parser and the DDS core:
// command codes, waveform codes and the parser state encoding.
package wave_pkg;

    localparam logic [7:0] CMD_WAVE = 8'h01;
    localparam logic [7:0] CMD_FREQ = 8'h02;
    localparam logic [7:0] CMD_AMP  = 8'h03;

    localparam logic [1:0] WAVE_SINE     = 2'd0;
    localparam logic [1:0] WAVE_SQUARE   = 2'd1;
    localparam logic [1:0] WAVE_TRIANGLE = 2'd2;
    localparam logic [1:0] WAVE_SAW      = 2'd3;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CMD  = 3'd1,
        DHI  = 3'd2,
        DLO  = 3'd3,
        CHK  = 3'd4
    } parse_state_e;

    function automatic logic [7:0] frame_chk(input logic [7:0] c,
                                             input logic [7:0] h,
                                             input logic [7:0] l);
        return c ^ h ^ l;
    endfunction

endpackage

// File: rtl/uart_cmd_parser.sv
// Parses 5-byte frames (HEADER, cmd, dhi, dlo, xor checksum) from the UART
// receiver and updates the DDS configuration registers.
//
// state | meaning
// IDLE  | waiting for HEADER
// CMD   | next byte is the command code
// DHI   | next byte is the data high byte
// DLO   | next byte is the data low byte
// CHK   | next byte is the checksum; frame is applied or rejected
module uart_cmd_parser
    import wave_pkg::*;
#(
    parameter logic [7:0]  HEADER   = 8'hAA,
    parameter int unsigned TIMEOUT  = 2000,
    parameter logic [15:0] FREQ_RST = 16'd1000
) (
    input  logic        clk_16u,
    input  logic        rst_n,
    input  logic [7:0]  data_in,
    input  logic        data_ready,
    input  logic        data_error,
    output logic [1:0]  wave_sel,
    output logic [15:0] freq_word,
    output logic [7:0]  amp,
    output logic        cfg_update,
    output logic        frame_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    parse_state_e     state_q, state_d;
    logic             dr_q, dr_d;
    logic             acc_q, acc_d;
    logic [7:0]       byte_q, byte_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       cmd_q, cmd_d;
    logic [7:0]       dhi_q, dhi_d;
    logic [7:0]       dlo_q, dlo_d;
    logic [1:0]       wave_sel_q, wave_sel_d;
    logic [15:0]      freq_word_q, freq_word_d;
    logic [7:0]       amp_q, amp_d;
    logic             cfg_update_q, cfg_update_d;
    logic             frame_err_q, frame_err_d;

    always_ff @(posedge clk_16u or negedge rst_n) begin
        if (!rst_n) begin
            // edge register starts high so a level held across reset is not a byte
            dr_q         <= 1'b1;
            acc_q        <= 1'b0;
            byte_q       <= '0;
            err_q        <= 1'b0;
            state_q      <= IDLE;
            cnt_q        <= '0;
            cmd_q        <= '0;
            dhi_q        <= '0;
            dlo_q        <= '0;
            wave_sel_q   <= WAVE_SINE;
            freq_word_q  <= FREQ_RST;
            amp_q        <= 8'hFF;
            cfg_update_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            dr_q         <= dr_d;
            acc_q        <= acc_d;
            byte_q       <= byte_d;
            err_q        <= err_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cmd_q        <= cmd_d;
            dhi_q        <= dhi_d;
            dlo_q        <= dlo_d;
            wave_sel_q   <= wave_sel_d;
            freq_word_q  <= freq_word_d;
            amp_q        <= amp_d;
            cfg_update_q <= cfg_update_d;
            frame_err_q  <= frame_err_d;
        end
    end

    always_comb begin
        dr_d         = data_ready;
        acc_d        = data_ready & ~dr_q;
        byte_d       = data_in;
        err_d        = data_error;
        state_d      = state_q;
        cnt_d        = cnt_q;
        cmd_d        = cmd_q;
        dhi_d        = dhi_q;
        dlo_d        = dlo_q;
        wave_sel_d   = wave_sel_q;
        freq_word_d  = freq_word_q;
        amp_d        = amp_q;
        cfg_update_d = 1'b0;
        frame_err_d  = 1'b0;

        if (acc_q) begin
            // an accepted byte always beats a coincident timeout
            cnt_d = '0;
            if (err_q) begin
                if (state_q != IDLE) begin
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        if (byte_q == HEADER) state_d = CMD;
                    end
                    CMD: begin
                        cmd_d   = byte_q;
                        state_d = DHI;
                    end
                    DHI: begin
                        dhi_d   = byte_q;
                        state_d = DLO;
                    end
                    DLO: begin
                        dlo_d   = byte_q;
                        state_d = CHK;
                    end
                    CHK: begin
                        state_d = IDLE;
                        if (byte_q != frame_chk(cmd_q, dhi_q, dlo_q)) begin
                            frame_err_d = 1'b1;
                        end else begin
                            case (cmd_q)
                                CMD_WAVE: begin
                                    wave_sel_d   = dlo_q[1:0];
                                    cfg_update_d = 1'b1;
                                end
                                CMD_FREQ: begin
                                    freq_word_d  = {dhi_q, dlo_q};
                                    cfg_update_d = 1'b1;
                                end
                                CMD_AMP: begin
                                    amp_d        = dlo_q;
                                    cfg_update_d = 1'b1;
                                end
                                default: frame_err_d = 1'b1;
                            endcase
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end else if (state_q != IDLE) begin
            if (cnt_q == CNT_MAX) begin
                state_d     = IDLE;
                frame_err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign wave_sel   = wave_sel_q;
    assign freq_word  = freq_word_q;
    assign amp        = amp_q;
    assign cfg_update = cfg_update_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: a frame-level reference model is
// compared against the DUT every cycle, plus literal end-of-scenario checks.
module tb_uart_cmd_parser;

    localparam logic [7:0]  HDR  = 8'hAA;
    localparam int          TO   = 2000;
    localparam logic [15:0] FRST = 16'd1000;

    logic        clk_16u = 1'b0;
    logic        rst_n   = 1'b1;
    logic [7:0]  data_in = 8'h00;
    logic        data_ready = 1'b0;
    logic        data_error = 1'b0;
    logic [1:0]  wave_sel;
    logic [15:0] freq_word;
    logic [7:0]  amp;
    logic        cfg_update;
    logic        frame_err;

    uart_cmd_parser #(
        .HEADER   (HDR),
        .TIMEOUT  (TO),
        .FREQ_RST (FRST)
    ) dut (
        .clk_16u    (clk_16u),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .data_ready (data_ready),
        .data_error (data_error),
        .wave_sel   (wave_sel),
        .freq_word  (freq_word),
        .amp        (amp),
        .cfg_update (cfg_update),
        .frame_err  (frame_err)
    );

    always #5 clk_16u = ~clk_16u;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int cfg_cnt  = 0;
    int err_cnt  = 0;
    bit chk_on   = 1'b0;

    // Reference model: frame position 0 = hunting for header, 1..4 = bytes seen.
    // Each offered byte takes effect two clocks after the clock it was offered on.
    typedef struct {
        int         due;
        logic [7:0] b;
        logic       e;
    } item_t;

    item_t      pend[$];
    int         ms;
    int         last_p;
    logic [7:0] mc, mh, ml;
    logic [1:0] m_wave;
    logic [15:0] m_freq;
    logic [7:0] m_amp;
    logic       exp_cfg, exp_err;

    task automatic model_reset();
        ms      = 0;
        last_p  = 0;
        mc      = 8'h00;
        mh      = 8'h00;
        ml      = 8'h00;
        m_wave  = 2'd0;
        m_freq  = FRST;
        m_amp   = 8'hFF;
        exp_cfg = 1'b0;
        exp_err = 1'b0;
        pend.delete();
    endtask

    task automatic m_byte(input logic [7:0] b, input logic e);
        if (e) begin
            if (ms != 0) begin
                exp_err = 1'b1;
                ms      = 0;
            end
        end else if (ms == 0) begin
            if (b == HDR) ms = 1;
        end else if (ms == 1) begin
            mc = b; ms = 2;
        end else if (ms == 2) begin
            mh = b; ms = 3;
        end else if (ms == 3) begin
            ml = b; ms = 4;
        end else begin
            ms = 0;
            if (b != (mc ^ mh ^ ml)) exp_err = 1'b1;
            else if (mc == 8'h01) begin m_wave = ml[1:0];  exp_cfg = 1'b1; end
            else if (mc == 8'h02) begin m_freq = {mh, ml}; exp_cfg = 1'b1; end
            else if (mc == 8'h03) begin m_amp  = ml;       exp_cfg = 1'b1; end
            else exp_err = 1'b1;
        end
    endtask

    always @(posedge clk_16u) begin
        item_t it;
        cyc++;
        exp_cfg = 1'b0;
        exp_err = 1'b0;
        if (rst_n) begin
            if (pend.size() > 0 && pend[0].due == cyc) begin
                it = pend.pop_front();
                m_byte(it.b, it.e);
                last_p = cyc;
            end else if (ms != 0 && cyc - last_p == TO + 1) begin
                exp_err = 1'b1;
                ms      = 0;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    always begin
        @(posedge clk_16u);
        #1;
        if (chk_on) begin
            chk("wave_sel", int'(wave_sel), int'(m_wave));
            chk("freq_word", int'(freq_word), int'(m_freq));
            chk("amp", int'(amp), int'(m_amp));
            chk("cfg_update", int'(cfg_update), int'(exp_cfg));
            chk("frame_err", int'(frame_err), int'(exp_err));
            chk("pulse_excl", int'(cfg_update & frame_err), 0);
            if (cfg_update) cfg_cnt++;
            if (frame_err)  err_cnt++;
        end
    end

    task automatic send(input logic [7:0] b, input logic e, input int hold);
        @(negedge clk_16u);
        data_in    = b;
        data_error = e;
        data_ready = 1'b1;
        pend.push_back('{cyc + 2, b, e});
        repeat (hold) @(negedge clk_16u);
        data_ready = 1'b0;
        data_error = 1'b0;
        repeat (2) @(negedge clk_16u);
    endtask

    task automatic frame(input logic [7:0] c, input logic [7:0] h,
                         input logic [7:0] l, input logic [7:0] x);
        send(HDR, 1'b0, 2);
        send(c, 1'b0, 2);
        send(h, 1'b0, 2);
        send(l, 1'b0, 2);
        send(x, 1'b0, 2);
        repeat (4) @(negedge clk_16u);
    endtask

    task automatic do_reset();
        @(negedge clk_16u);
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk_16u);
        rst_n = 1'b1;
    endtask

    task automatic clr_cnt();
        cfg_cnt = 0;
        err_cnt = 0;
    endtask

    initial begin
        model_reset();
        do_reset();
        chk_on = 1'b1;
        repeat (3) @(negedge clk_16u);
        chk("rst_wave", int'(wave_sel), 0);
        chk("rst_freq", int'(freq_word), 1000);
        chk("rst_amp", int'(amp), 8'hFF);

        // bad checksum leaves freq_word at its reset value
        clr_cnt();
        frame(8'h02, 8'h12, 8'h34, 8'h25);
        chk("badsum_freq", int'(freq_word), 1000);
        chk("badsum_err", err_cnt, 1);
        chk("badsum_cfg", cfg_cnt, 0);

        clr_cnt();
        frame(8'h02, 8'h12, 8'h34, 8'h24);
        chk("freq_val", int'(freq_word), 16'h1234);
        chk("freq_cfg", cfg_cnt, 1);
        chk("freq_err", err_cnt, 0);

        clr_cnt();
        frame(8'h01, 8'h00, 8'h03, 8'h02);
        chk("wave_val", int'(wave_sel), 3);
        frame(8'h03, 8'h00, 8'h80, 8'h83);
        chk("amp_val", int'(amp), 8'h80);
        chk("wave_amp_cfg", cfg_cnt, 2);

        // receiver error: silent in IDLE, rejects frame mid-frame
        clr_cnt();
        send(8'h55, 1'b1, 2);
        send(HDR, 1'b0, 2);
        send(8'h02, 1'b1, 2);
        repeat (4) @(negedge clk_16u);
        chk("rxerr_err", err_cnt, 1);

        // header byte inside a frame is plain data
        clr_cnt();
        frame(8'h03, HDR, 8'h40, 8'h03 ^ HDR ^ 8'h40);
        chk("hdr_data_amp", int'(amp), 8'h40);
        chk("hdr_data_cfg", cfg_cnt, 1);

        clr_cnt();
        send(HDR, 1'b0, 2);
        send(8'h02, 1'b0, 2);
        repeat (TO + 10) @(negedge clk_16u);
        chk("timeout_err", err_cnt, 1);
        frame(8'h01, 8'h00, 8'h01, 8'h00);
        chk("post_to_wave", int'(wave_sel), 1);
        chk("post_to_err", err_cnt, 1);

        // long level counts once
        clr_cnt();
        send(HDR, 1'b0, 50);
        send(8'h11, 1'b0, 2);
        send(8'h22, 1'b0, 2);
        send(8'h33, 1'b0, 2);
        send(8'h00, 1'b0, 2);
        repeat (4) @(negedge clk_16u);
        chk("level_err", err_cnt, 1);
        chk("level_cfg", cfg_cnt, 0);

        // reset mid-frame with data_ready held high across reset
        clr_cnt();
        send(HDR, 1'b0, 2);
        send(8'h02, 1'b0, 2);
        send(8'h12, 1'b0, 2);
        @(negedge clk_16u);
        data_in    = 8'h34;
        data_ready = 1'b1;
        rst_n      = 1'b0;
        model_reset();
        repeat (3) @(negedge clk_16u);
        rst_n = 1'b1;
        repeat (5) @(negedge clk_16u);
        data_ready = 1'b0;
        repeat (2) @(negedge clk_16u);
        send(8'h34, 1'b0, 2);
        send(8'h24, 1'b0, 2);
        repeat (4) @(negedge clk_16u);
        chk("rst2_wave", int'(wave_sel), 0);
        chk("rst2_freq", int'(freq_word), 1000);
        chk("rst2_amp", int'(amp), 8'hFF);
        chk("rst2_cfg", cfg_cnt, 0);
        chk("rst2_err", err_cnt, 0);

        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
